digit_serial_adder: RTL

- Parametrised multi-cycle adder. Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a DIGIT-bit ripple cell built from full-adder stages.
- Trades latency for area in datapaths where a full-width ripple adder would not close timing or is too large.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/digit_serial_adder_pkg.sv | 47 ++++
 rtl/digit_serial_adder_cell.sv | 27 ++
 rtl/digit_serial_adder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding, derived-size
// helpers, parameter legality check and the single-bit full-adder equations.
package digit_serial_adder_pkg;

    // FSM encoding. The top keeps its state register as plain logic [1:0] and
    // maps these values onto localparam constants.
    typedef enum logic [1:0] {
        STATE_IDLE = 2'd0,
        STATE_RUN  = 2'd1,
        STATE_DONE = 2'd2
    } state_e;

    // Number of RUN cycles needed to sweep the whole operand.
    function automatic int num_digits(input int width, input int digit);
        if (digit > 0) begin
            return width / digit;
        end
        return 1;
    endfunction

    // Digit counter width: clog2 of the digit count, never narrower than 1.
    function automatic int cnt_width(input int nd);
        if (nd > 1) begin
            return $clog2(nd);
        end
        return 1;
    endfunction

    // Legal configurations: WIDTH >= 2, DIGIT in 1..WIDTH and DIGIT | WIDTH.
    function automatic bit params_legal(input int width, input int digit);
        if (width < 2)      return 1'b0;
        if (digit < 1)      return 1'b0;
        if (digit > width)  return 1'b0;
        return (width % digit) == 0;
    endfunction

    // Full-adder sum bit.
    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    // Full-adder carry bit: generate, or propagate an incoming carry.
    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | ((x ^ y) & ci);
    endfunction

endpackage : digit_serial_adder_pkg

// File: rtl/digit_serial_adder_cell.sv
// DIGIT-bit ripple-carry adder cell used by the digit-serial adder.
// Purely combinational: one full-adder stage per bit, carry rippling upward.
module digit_add_cell
    import digit_serial_adder_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    // c[i] is the carry into bit i; c[DIGIT] leaves the cell.
    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s[i]   = fa_sum(x[i], y[i], c[i]);
        assign c[i+1] = fa_carry(x[i], y[i], c[i]);
    end

    assign co = c[DIGIT];

endmodule : digit_add_cell

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus a carry-in, DIGIT
// bits per clock, reusing one DIGIT-bit ripple cell for every digit.
// Optional subtract mode is enabled with the macro DIGIT_SERIAL_ADDER_SUB_EN
// (adds a 'sub' input; a - b is computed as a + ~b + 1).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Operands are taken only on such an edge (in_valid && in_ready,
// ready only in IDLE). The result is offered with out_valid in DONE and is
// held unchanged until the edge where out_valid && out_ready; neither side
// may assume a transfer without both signals high on the same edge.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    // ------------------------------------------------------------------
    // Derived sizes and FSM encoding
    // ------------------------------------------------------------------
    localparam int NUM_DIGITS = num_digits(WIDTH, DIGIT);
    localparam int CNT_W      = cnt_width(NUM_DIGITS);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    localparam logic [1:0] ST_IDLE = STATE_IDLE;
    localparam logic [1:0] ST_RUN  = STATE_RUN;
    localparam logic [1:0] ST_DONE = STATE_DONE;

    // Illegal WIDTH/DIGIT combinations stop elaboration.
    if (!params_legal(WIDTH, DIGIT)) begin : g_param_check
        $error("digit_serial_adder: WIDTH=%0d DIGIT=%0d illegal (need WIDTH>=2, DIGIT divides WIDTH)",
               WIDTH, DIGIT);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [WIDTH-1:0] sum_q,     sum_d;
    logic             carry_q,   carry_d;
    logic             a_msb_q,   a_msb_d;
    logic             b_msb_q,   b_msb_d;
    logic             cout_q,    cout_d;
    logic             ovf_q,     ovf_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic accept;
    logic release_res;
    logic in_run;
    logic last_digit;

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign accept      = in_valid && in_ready;
    assign release_res = out_valid && out_ready;
    assign in_run      = (state_q == ST_RUN);
    assign last_digit  = (cnt_q == LAST_CNT);

    // ------------------------------------------------------------------
    // Operand preparation on the accept edge
    // ------------------------------------------------------------------
    logic             sub_op;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef DIGIT_SERIAL_ADDER_SUB_EN
    assign sub_op = sub;
`else
    assign sub_op = 1'b0;
`endif

    // Subtraction is a + ~b + 1: invert b and force the initial carry.
    assign b_eff   = sub_op ? ~b : b;
    assign cin_eff = sub_op ? 1'b1 : carry_in;

    // ------------------------------------------------------------------
    // Shared DIGIT-bit adder cell
    // ------------------------------------------------------------------
    logic [DIGIT-1:0] cell_s;
    logic             cell_co;

    digit_add_cell #(
        .DIGIT (DIGIT)
    ) u_cell (
        .x  (a_q[DIGIT-1:0]),
        .y  (b_q[DIGIT-1:0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    // New digit enters at the top of the sum register; after NUM_DIGITS
    // shifts the first digit has reached bit 0.
    logic [WIDTH-1:0] sum_shift;

    if (DIGIT == WIDTH) begin : g_sum_single
        assign sum_shift = cell_s;
    end else begin : g_sum_shift
        assign sum_shift = {cell_s, sum_q[WIDTH-1:DIGIT]};
    end

    // ------------------------------------------------------------------
    // FSM next-state: IDLE -> RUN on accept, RUN -> DONE on last digit,
    // DONE -> IDLE when the result is taken.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)      state_d = ST_RUN;
            ST_RUN:  if (last_digit)  state_d = ST_DONE;
            ST_DONE: if (release_res) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Digit counter: cleared on accept, advanced once per RUN cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (in_run) begin
            cnt_d = last_digit ? '0 : cnt_q + 1'b1;
        end
    end

    // Datapath next-state: load operands on accept, shift one digit per RUN cycle.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        if (accept) begin
            a_d     = a;
            b_d     = b_eff;
            carry_d = cin_eff;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b_eff[WIDTH-1];
        end else if (in_run) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            sum_d   = sum_shift;
            carry_d = cell_co;
        end
    end

    // Result flags are captured on the last digit so they hold through DONE.
    always_comb begin
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (in_run && last_digit) begin
            cout_d = cell_co;
            ovf_d  = (a_msb_q == b_msb_q) && (cell_s[DIGIT-1] != a_msb_q);
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // FSM and digit counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand/sum shift registers, running carry and latched sign bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    // Registered carry-out and signed-overflow flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule : digit_serial_adder
